// File: rtl/prco_constants.sv
// Shared constants for the prco control sequencer: state encoding and
// write-back source select.
package prco_constants;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_REGRD  = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_HALT   = 3'd6
    } seq_state_e;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/prco_req_hold.sv
// Memory request holder: raises the request on issue, keeps address and write
// enable frozen until the acknowledge, then drops everything the cycle after.
module prco_req_hold #(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_issue,
    input  logic              i_issue_data,
    input  logic              i_issue_we,
    input  logic [ADDR_W-1:0] i_issue_addr,
    input  logic              i_ack,
    output logic              q_req,
    output logic              q_we,
    output logic              q_data_phase,
    output logic [ADDR_W-1:0] q_addr
);

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Set on issue, clear on a completed handshake; an ack without a request is ignored.
    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        if (i_issue) begin
            req_d   = 1'b1;
            we_d    = i_issue_we;
            phase_d = i_issue_data;
            addr_d  = i_issue_data ? i_issue_addr : addr_q;
        end else if (req_q && i_ack) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            phase_d = 1'b0;
        end else begin
            req_d   = req_q;
        end
    end

    // Request state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            phase_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
        end
    end

    assign q_req        = req_q;
    assign q_we         = we_q;
    assign q_data_phase = phase_q;
    assign q_addr       = addr_q;

endmodule

// File: rtl/prco_ctrl_seq.sv
// Multi-cycle control sequencer for the prco core: fetch/decode/regread/exec/
// mem/writeback with a req/ack memory handshake, PC update and retire counter.
module prco_ctrl_seq
    import prco_constants::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    output logic              q_mem_req,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic              q_mem_we,
    output logic              q_mem_data_phase,
    input  logic              i_mem_ack,
    output logic              q_ce_dec,
    output logic              q_ce_reg,
    output logic              q_ce_alu,
    input  logic              i_dec_req_ram,
    input  logic              i_dec_mem_we,
    input  logic              i_dec_reg_we,
    input  logic              i_dec_halt,
    input  logic [ADDR_W-1:0] i_alu_result,
    input  logic              i_alu_br_taken,
    input  logic [ADDR_W-1:0] i_alu_br_target,
    output logic              q_reg_we,
    output logic              q_wb_sel,
    output logic [ADDR_W-1:0] q_pc,
    output logic              q_instr_strobe,
    output logic              q_halted,
    output logic [CNT_W-1:0]  q_retired
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              ce_dec_q, ce_dec_d, ce_reg_q, ce_reg_d, ce_alu_q, ce_alu_d;
    logic              reg_we_q, reg_we_d, strobe_q, strobe_d;
    logic              wb_sel_q, wb_sel_d, halted_q, halted_d;
    logic              issue_s, issue_data_s, issue_we_s;
    logic              req_s, we_s, phase_s;
    logic [ADDR_W-1:0] data_addr_s;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc,
                                                  input logic              taken,
                                                  input logic [ADDR_W-1:0] target);
        return taken ? target : pc + ADDR_W'(1'b1);
    endfunction

    prco_req_hold #(.ADDR_W(ADDR_W)) u_req_hold (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_issue      (issue_s),
        .i_issue_data (issue_data_s),
        .i_issue_we   (issue_we_s),
        .i_issue_addr (i_alu_result),
        .i_ack        (i_mem_ack),
        .q_req        (req_s),
        .q_we         (we_s),
        .q_data_phase (phase_s),
        .q_addr       (data_addr_s)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= SEQ_FETCH;
            pc_q      <= RESET_VEC;
            retired_q <= {CNT_W{1'b0}};
            ce_dec_q  <= 1'b0;
            ce_reg_q  <= 1'b0;
            ce_alu_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            strobe_q  <= 1'b0;
            wb_sel_q  <= WB_SEL_ALU;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            ce_dec_q  <= ce_dec_d;
            ce_reg_q  <= ce_reg_d;
            ce_alu_q  <= ce_alu_d;
            reg_we_q  <= reg_we_d;
            strobe_q  <= strobe_d;
            wb_sel_q  <= wb_sel_d;
            halted_q  <= halted_d;
        end
    end

    // Next state; fetch requests are issued on FETCH entry (or from idle FETCH) when enabled.
    always_comb begin
        state_d      = state_q;
        issue_s      = 1'b0;
        issue_data_s = 1'b0;
        issue_we_s   = 1'b0;
        case (state_q)
            SEQ_FETCH: begin
                if (req_s) begin
                    state_d = i_mem_ack ? SEQ_DECODE : SEQ_FETCH;
                end else begin
                    issue_s = i_en;
                end
            end
            SEQ_DECODE: state_d = SEQ_REGRD;
            SEQ_REGRD:  state_d = SEQ_EXEC;
            SEQ_EXEC: begin
                if (i_dec_req_ram) begin
                    state_d      = SEQ_MEM;
                    issue_s      = 1'b1;
                    issue_data_s = 1'b1;
                    issue_we_s   = i_dec_mem_we;
                end else begin
                    state_d = SEQ_WB;
                end
            end
            SEQ_MEM: state_d = (req_s && i_mem_ack) ? SEQ_WB : SEQ_MEM;
            SEQ_WB: begin
                if (i_dec_halt) begin
                    state_d = SEQ_HALT;
                end else begin
                    state_d = SEQ_FETCH;
                    issue_s = i_en;
                end
            end
            SEQ_HALT: state_d = SEQ_HALT;
            default:  state_d = SEQ_FETCH;
        endcase
    end

    // Registered outputs decoded from the upcoming state.
    always_comb begin
        ce_dec_d  = (state_d == SEQ_DECODE);
        ce_reg_d  = (state_d == SEQ_REGRD);
        ce_alu_d  = (state_d == SEQ_EXEC);
        strobe_d  = (state_d == SEQ_WB);
        reg_we_d  = (state_d == SEQ_WB) && i_dec_reg_we;
        halted_d  = (state_d == SEQ_HALT);
        pc_d      = pc_q;
        retired_d = retired_q;
        if (state_q == SEQ_EXEC && state_d == SEQ_MEM) begin
            wb_sel_d = i_dec_mem_we ? WB_SEL_ALU : WB_SEL_MEM;
        end else if (state_d == SEQ_MEM || state_d == SEQ_WB) begin
            wb_sel_d = wb_sel_q;
        end else begin
            wb_sel_d = WB_SEL_ALU;
        end
        if (state_q == SEQ_WB) begin
            pc_d      = next_pc(pc_q, i_alu_br_taken, i_alu_br_target);
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            pc_d      = pc_q;
        end
    end

    assign q_mem_req        = req_s;
    assign q_mem_we         = we_s;
    assign q_mem_data_phase = phase_s;
    assign q_mem_addr       = phase_s ? data_addr_s : pc_q;
    assign q_ce_dec         = ce_dec_q;
    assign q_ce_reg         = ce_reg_q;
    assign q_ce_alu         = ce_alu_q;
    assign q_reg_we         = reg_we_q;
    assign q_wb_sel         = wb_sel_q;
    assign q_pc             = pc_q;
    assign q_instr_strobe   = strobe_q;
    assign q_halted         = halted_q;
    assign q_retired        = retired_q;

endmodule

// File: tb/tb_prco_ctrl_seq.sv
// Scoreboard bench for prco_ctrl_seq: expected addresses are queued when an
// instruction is set up and popped when the DUT raises the matching request.
module tb_prco_ctrl_seq;

    typedef struct {
        logic        ram, we, rwe, halt, taken;
        logic [15:0] alu, tgt;
        int          fw, dw;
        logic        drop_en, rst_mem;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n, i_en, i_mem_ack;
    logic        i_dec_req_ram, i_dec_mem_we, i_dec_reg_we, i_dec_halt, i_alu_br_taken;
    logic [15:0] i_alu_result, i_alu_br_target;
    logic        q_mem_req, q_mem_we, q_mem_data_phase;
    logic [15:0] q_mem_addr, q_pc, q_retired;
    logic        q_ce_dec, q_ce_reg, q_ce_alu, q_reg_we, q_wb_sel, q_instr_strobe, q_halted;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          prev_cyc = 0;
    bit          prev_valid = 1'b0;
    logic [15:0] mpc = 16'h0000;
    logic [15:0] mret = 16'h0000;
    logic [15:0] exp_q[$];
    instr_t      prog[$];

    prco_ctrl_seq dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(i_en),
        .q_mem_req(q_mem_req), .q_mem_addr(q_mem_addr), .q_mem_we(q_mem_we),
        .q_mem_data_phase(q_mem_data_phase), .i_mem_ack(i_mem_ack),
        .q_ce_dec(q_ce_dec), .q_ce_reg(q_ce_reg), .q_ce_alu(q_ce_alu),
        .i_dec_req_ram(i_dec_req_ram), .i_dec_mem_we(i_dec_mem_we),
        .i_dec_reg_we(i_dec_reg_we), .i_dec_halt(i_dec_halt),
        .i_alu_result(i_alu_result), .i_alu_br_taken(i_alu_br_taken),
        .i_alu_br_target(i_alu_br_target), .q_reg_we(q_reg_we), .q_wb_sel(q_wb_sel),
        .q_pc(q_pc), .q_instr_strobe(q_instr_strobe), .q_halted(q_halted),
        .q_retired(q_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(logic ram, logic we, logic rwe, logic halt, logic taken,
                                  logic [15:0] alu, logic [15:0] tgt, int fw, int dw,
                                  logic drop_en, logic rst_mem);
        instr_t r;
        r.ram = ram; r.we = we; r.rwe = rwe; r.halt = halt; r.taken = taken;
        r.alu = alu; r.tgt = tgt; r.fw = fw; r.dw = dw;
        r.drop_en = drop_en; r.rst_mem = rst_mem;
        return r;
    endfunction

    task automatic reset_in_mem();
        rst_n = 1'b0;
        i_en  = 1'b0;
        #1;
        check_eq("rst_req", q_mem_req, 1'b0);
        check_eq("rst_retired", q_retired, 16'h0000);
        check_eq("rst_pc", q_pc, 16'h0000);
        check_eq("rst_flags", {q_mem_data_phase, q_mem_we, q_wb_sel, q_halted}, 4'b0000);
        exp_q.delete();
        mpc = 16'h0000;
        mret = 16'h0000;
        prev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        check_eq("late_ack_req", q_mem_req, 1'b0);
        check_eq("late_ack_ce", {q_ce_dec, q_ce_reg, q_ce_alu}, 3'b000);
        @(negedge clk);
        check_eq("late_ack_idle", q_mem_req, 1'b0);
        i_en = 1'b1;
    endtask

    task automatic run_instr(input instr_t ins);
        logic [15:0] ea;
        int          n;
        i_dec_req_ram = ins.ram; i_dec_mem_we = ins.we; i_dec_reg_we = ins.rwe;
        i_dec_halt = ins.halt; i_alu_result = ins.alu;
        i_alu_br_taken = ins.taken; i_alu_br_target = ins.tgt;
        exp_q.push_back(mpc);
        if (ins.ram) exp_q.push_back(ins.alu);
        n = 0;
        while (q_mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q_mem_req !== 1'b1) begin
            check_eq("fetch_timeout", q_mem_req, 1'b1);
            return;
        end
        ea = exp_q.pop_front();
        check_eq("fetch_addr", q_mem_addr, ea);
        check_eq("fetch_phase_we", {q_mem_data_phase, q_mem_we}, 2'b00);
        for (int w = 0; w < ins.fw; w++) begin
            if (ins.drop_en && w == 0) i_en = 1'b0;
            @(negedge clk);
            check_eq("fetch_hold", {q_mem_req, q_mem_addr}, {1'b1, ea});
        end
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        i_en = 1'b1;
        check_eq("decode", {q_mem_req, q_ce_dec, q_ce_reg, q_ce_alu}, 4'b0100);
        @(negedge clk);
        check_eq("regrd", {q_mem_req, q_ce_dec, q_ce_reg, q_ce_alu}, 4'b0010);
        @(negedge clk);
        check_eq("exec", {q_mem_req, q_ce_dec, q_ce_reg, q_ce_alu}, 4'b0001);
        @(negedge clk);
        if (ins.ram) begin
            ea = exp_q.pop_front();
            check_eq("data_req", {q_mem_req, q_mem_data_phase, q_mem_we, q_wb_sel},
                     {1'b1, 1'b1, ins.we, ~ins.we});
            check_eq("data_addr", q_mem_addr, ea);
            for (int w = 0; w < ins.dw; w++) begin
                if (ins.rst_mem && w == 1) begin
                    check_eq("pre_rst_retired", q_retired, mret);
                    reset_in_mem();
                    return;
                end
                @(negedge clk);
                check_eq("data_hold", {q_mem_req, q_mem_we, q_mem_addr}, {1'b1, ins.we, ea});
            end
            i_mem_ack = 1'b1;
            @(negedge clk);
            i_mem_ack = 1'b0;
        end
        check_eq("wb", {q_instr_strobe, q_reg_we, q_wb_sel, q_mem_req},
                 {1'b1, ins.rwe, ins.ram & ~ins.we, 1'b0});
        check_eq("wb_pc", q_pc, mpc);
        if (prev_valid) check_eq("interval", cyc - prev_cyc, 5 + ins.fw + (ins.ram ? ins.dw + 1 : 0));
        prev_cyc = cyc;
        prev_valid = 1'b1;
        mpc = ins.taken ? ins.tgt : mpc + 16'h0001;
        mret = mret + 16'h0001;
        @(negedge clk);
        check_eq("pc_next", q_pc, mpc);
        check_eq("retired", q_retired, mret);
        check_eq("post_wb", {q_instr_strobe, q_reg_we, q_halted}, {1'b0, 1'b0, ins.halt});
    endtask

    initial begin
        rst_n = 1'b0; i_en = 1'b0; i_mem_ack = 1'b0;
        i_dec_req_ram = 1'b0; i_dec_mem_we = 1'b0; i_dec_reg_we = 1'b0; i_dec_halt = 1'b0;
        i_alu_result = 16'h0000; i_alu_br_taken = 1'b0; i_alu_br_target = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("reset_out", {q_mem_req, q_mem_we, q_mem_data_phase, q_ce_dec, q_ce_reg,
                               q_ce_alu, q_reg_we, q_wb_sel, q_instr_strobe, q_halted}, 10'd0);
        check_eq("reset_pc", q_pc, 16'h0000);
        check_eq("reset_retired", q_retired, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq("en_low_idle", q_mem_req, 1'b0);
        end
        i_en = 1'b1;

        for (int i = 0; i < 3; i++)
            prog.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 0, 1'b1, 1'b0));
        prog.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 2, 2, 1'b0, 1'b0));
        prog.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 0, 4, 1'b0, 1'b1));
        prog.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 0, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 0, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 0, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0, 1'b0, 1'b0));
        prog.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0));
        foreach (prog[k]) run_instr(prog[k]);

        for (int i = 0; i < 20; i++) begin
            i_mem_ack = (i % 2 == 0);
            @(negedge clk);
            check_eq("halt_quiet", {q_mem_req, q_halted, q_instr_strobe, q_ce_dec, q_ce_reg, q_ce_alu},
                     6'b010000);
            check_eq("halt_retired", q_retired, mret);
        end
        i_mem_ack = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
